// File: rtl/rs_pkg.sv
// Shared reservation-station types: widths, entry record, ALU opcodes and a tag-match helper.
// Used by alu_reserve_station and rs_select (which is also reused by the LSB station).
package rs_pkg;

  localparam int TAG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int OP_W       = 5;
  localparam int RS_ENTRIES = 8;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic              q1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] v1;
    logic              q2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] v2;
  } rs_entry_t;

  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd5;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'd6;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'd7;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'd8;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'd9;

  // An operand still waiting on tag t is satisfied by a valid broadcast of the same tag.
  function automatic logic tag_hit(input logic pending, input logic [TAG_W-1:0] t,
                                   input logic wb_en, input logic [TAG_W-1:0] wb_tag);
    return pending & wb_en & (t == wb_tag);
  endfunction

endpackage

// File: rtl/rs_select.sv
// Issue selector: ready vector -> one-hot grant + valid.
// RS_AGE_SELECT_EN defined: oldest-first via an N x N age matrix; undefined: lowest index wins.
module rs_select
  import rs_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] busy,
  input  logic [N-1:0] ready,
  output logic [N-1:0] grant,
  output logic         valid
);

  assign valid = |ready;

`ifdef RS_AGE_SELECT_EN
  // older_q[j][i] set means entry j was allocated before entry i.
  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < N; i++) begin
      if (alloc[i]) begin
        for (int j = 0; j < N; j++) older_d[j][i] = busy[j];
        older_d[i] = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) older_q[j] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < N; j++) blocked = blocked | (ready[j] & older_q[j][i]);
      grant[i] = ready[i] & ~blocked;
    end
  end
`else
  logic unused_age;
  assign unused_age = ^{clk, rst, alloc, busy};

  // Isolate the lowest set bit of the ready vector.
  assign grant = ready & (~ready + {{(N-1){1'b0}}, 1'b1});
`endif

endmodule

// File: rtl/alu_reserve_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive, issues one per cycle.
// Issue order is set by rs_select; define RS_AGE_SELECT_EN for oldest-first selection.
module alu_reserve_station
  import rs_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic              disp_q1,
  input  logic              disp_q2,
  input  logic [TAG_W-1:0]  disp_t1,
  input  logic [TAG_W-1:0]  disp_t2,
  input  logic [DATA_W-1:0] disp_v1,
  input  logic [DATA_W-1:0] disp_v2,
  input  logic              wb_en,
  input  logic [TAG_W-1:0]  wb_vregid,
  input  logic [DATA_W-1:0] wb_val,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_dest
);

  rs_entry_t ent_q [ENTRIES];
  rs_entry_t ent_d [ENTRIES];

  logic [ENTRIES-1:0] busy, ready, alloc, grant;
  logic sel_valid, disp_fire, iss_fire, wb_live;
  logic bp1, bp2;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      busy[i]  = ent_q[i].busy;
      ready[i] = ent_q[i].busy & ~ent_q[i].q1 & ~ent_q[i].q2;
    end
  end

  // Lowest free slot: lowest zero bit of busy.
  assign alloc      = ~busy & (busy + {{(ENTRIES-1){1'b0}}, 1'b1});
  assign disp_ready = ~rst & ~(&busy);
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign wb_live    = wb_en & ~flush;

  rs_select #(.N(ENTRIES)) u_select (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc & {ENTRIES{disp_fire}}),
    .busy  (busy),
    .ready (ready),
    .grant (grant),
    .valid (sel_valid)
  );

  assign iss_valid = sel_valid & ~flush & ~rst;
  assign iss_fire  = iss_valid & iss_ready;

  always_comb begin
    iss_op   = '0;
    iss_a    = '0;
    iss_b    = '0;
    iss_dest = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant[i]) begin
        iss_op   = iss_op   | ent_q[i].op;
        iss_a    = iss_a    | ent_q[i].v1;
        iss_b    = iss_b    | ent_q[i].v2;
        iss_dest = iss_dest | ent_q[i].dest;
      end
    end
  end

  // A dispatching operand whose tag is on the broadcast this cycle is captured directly.
  assign bp1 = tag_hit(disp_q1, disp_t1, wb_live, wb_vregid);
  assign bp2 = tag_hit(disp_q2, disp_t2, wb_live, wb_vregid);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (tag_hit(ent_q[i].busy & ent_q[i].q1, ent_q[i].t1, wb_live, wb_vregid)) begin
        ent_d[i].q1 = 1'b0;
        ent_d[i].v1 = wb_val;
      end
      if (tag_hit(ent_q[i].busy & ent_q[i].q2, ent_q[i].t2, wb_live, wb_vregid)) begin
        ent_d[i].q2 = 1'b0;
        ent_d[i].v2 = wb_val;
      end
      if (iss_fire & grant[i]) ent_d[i].busy = 1'b0;
      if (disp_fire & alloc[i]) begin
        ent_d[i].busy = 1'b1;
        ent_d[i].op   = disp_op;
        ent_d[i].dest = disp_dest;
        ent_d[i].q1   = disp_q1 & ~bp1;
        ent_d[i].t1   = disp_t1;
        ent_d[i].v1   = bp1 ? wb_val : disp_v1;
        ent_d[i].q2   = disp_q2 & ~bp2;
        ent_d[i].t2   = disp_t2;
        ent_d[i].v2   = bp2 ? wb_val : disp_v2;
      end
      if (flush) ent_d[i].busy = 1'b0;
    end
  end

  // NOTE: only busy needs reset; payload fields are never observed while busy is clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i].busy <= 1'b0;
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: tb/tb_alu_reserve_station.sv
// Bench for alu_reserve_station: slot-level behavioural model checked every cycle plus directed literals.
// Build with RS_AGE_SELECT_EN defined to exercise oldest-first selection.
module tb_alu_reserve_station;
  import rs_pkg::*;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst, flush, disp_valid, disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_dest, disp_t1, disp_t2;
  logic              disp_q1, disp_q2;
  logic [DATA_W-1:0] disp_v1, disp_v2;
  logic              wb_en;
  logic [TAG_W-1:0]  wb_vregid;
  logic [DATA_W-1:0] wb_val;
  logic              iss_valid, iss_ready;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_a, iss_b;
  logic [TAG_W-1:0]  iss_dest;

  always #5 clk = ~clk;

  alu_reserve_station #(.ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_t1(disp_t1), .disp_t2(disp_t2),
    .disp_v1(disp_v1), .disp_v2(disp_v2),
    .wb_en(wb_en), .wb_vregid(wb_vregid), .wb_val(wb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_a(iss_a), .iss_b(iss_b), .iss_dest(iss_dest)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slots hold pending ops; age is a dispatch sequence number.
  typedef struct {
    bit                busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    bit                q1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] v1;
    bit                q2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] v2;
    int                seq;
  } m_ent_t;

  m_ent_t m [N];
  int     m_seq  = 0;
  bit     m_init = 0;

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_sel();
    int best = -1;
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && !m[i].q1 && !m[i].q2) begin
`ifdef RS_AGE_SELECT_EN
        if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  task automatic model_step();
    int s, f;
    if (rst) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_seq  = 0;
      m_init = 1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
    end else begin
      s = m_sel();
      f = m_free();
      if (wb_en) begin
        for (int i = 0; i < N; i++) begin
          if (m[i].busy && m[i].q1 && m[i].t1 == wb_vregid) begin m[i].q1 = 0; m[i].v1 = wb_val; end
          if (m[i].busy && m[i].q2 && m[i].t2 == wb_vregid) begin m[i].q2 = 0; m[i].v2 = wb_val; end
        end
      end
      if (s >= 0 && iss_ready) m[s].busy = 0;
      if (disp_valid && f >= 0) begin
        m[f].busy = 1;
        m[f].op   = disp_op;
        m[f].dest = disp_dest;
        m[f].t1   = disp_t1;
        m[f].t2   = disp_t2;
        if (disp_q1 && wb_en && disp_t1 == wb_vregid) begin m[f].q1 = 0; m[f].v1 = wb_val; end
        else begin m[f].q1 = disp_q1; m[f].v1 = disp_v1; end
        if (disp_q2 && wb_en && disp_t2 == wb_vregid) begin m[f].q2 = 0; m[f].v2 = wb_val; end
        else begin m[f].q2 = disp_q2; m[f].v2 = disp_v2; end
        m[f].seq = m_seq;
        m_seq++;
      end
    end
  endtask

  task automatic compare();
    int s;
    bit exp_v;
    if (rst) begin
      check("m_rst_disp_ready", disp_ready, 0);
      check("m_rst_iss_valid", iss_valid, 0);
    end else begin
      s = m_sel();
      exp_v = (s >= 0) && !flush;
      check("m_disp_ready", disp_ready, m_free() >= 0);
      check("m_iss_valid", iss_valid, exp_v);
      if (exp_v) begin
        check("m_iss_op", iss_op, m[s].op);
        check("m_iss_a", iss_a, m[s].v1);
        check("m_iss_b", iss_b, m[s].v2);
        check("m_iss_dest", iss_dest, m[s].dest);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_init) compare();
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  task automatic idle();
    disp_valid = 0;
    wb_en      = 0;
    flush      = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                      input logic q1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                      input logic q2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
    disp_valid = 1;
    disp_op    = op;
    disp_dest  = dest;
    disp_q1    = q1;
    disp_t1    = t1;
    disp_v1    = v1;
    disp_q2    = q2;
    disp_t2    = t2;
    disp_v2    = v2;
  endtask

  task automatic wb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
    wb_en     = 1;
    wb_vregid = tag;
    wb_val    = val;
  endtask

  initial begin
    rst = 1;
    idle();
    iss_ready = 0;
    disp_op = '0; disp_dest = '0; disp_q1 = 0; disp_q2 = 0;
    disp_t1 = '0; disp_t2 = '0; disp_v1 = '0; disp_v2 = '0;
    wb_vregid = '0; wb_val = '0;
    repeat (2) @(posedge clk);
    at_neg();
    check("reset_disp_ready", disp_ready, 0);
    check("reset_iss_valid", iss_valid, 0);
    step();
    rst = 0;
    at_neg();
    check("post_reset_disp_ready", disp_ready, 1);
    check("post_reset_iss_valid", iss_valid, 0);

    // Ready-at-dispatch op issues one cycle later.
    step(); iss_ready = 1; disp(ALU_ADD, 7, 0, 0, 3, 0, 0, 4);
    at_neg(); check("t1_not_same_cycle", iss_valid, 0);
    step();
    at_neg();
    check("t1_valid", iss_valid, 1);
    check("t1_a", iss_a, 3);
    check("t1_b", iss_b, 4);
    check("t1_dest", iss_dest, 7);
    check("t1_op", iss_op, ALU_ADD);
    step();
    at_neg(); check("t1_drained", iss_valid, 0);

    // Wakeup of operand 1 from a later broadcast.
    step(); disp(ALU_SUB, 1, 1, 5, 0, 0, 0, 2);
    step();
    step(); wb(5, 32'h10);
    at_neg(); check("t2_wake_cycle", iss_valid, 0);
    step();
    at_neg();
    check("t2_valid", iss_valid, 1);
    check("t2_a", iss_a, 32'h10);
    check("t2_b", iss_b, 2);

    // Both operands wake on one broadcast.
    step(); disp(ALU_AND, 2, 1, 6, 0, 1, 6, 0);
    step(); wb(6, 32'h55);
    step();
    at_neg();
    check("both_valid", iss_valid, 1);
    check("both_a", iss_a, 32'h55);
    check("both_b", iss_b, 32'h55);

    // Same-cycle bypass into operand 2.
    step(); disp(ALU_OR, 3, 0, 0, 1, 1, 9, 0); wb(9, 32'hAB);
    step();
    at_neg();
    check("t3_valid", iss_valid, 1);
    check("t3_b", iss_b, 32'hAB);
    check("t3_a", iss_a, 1);
    step();

    // Fill all slots waiting on tag 3, then drain one per cycle.
    for (int k = 0; k < N; k++) begin
      step(); disp(ALU_XOR, TAG_W'(8 + k), 1, 3, 0, 0, 0, DATA_W'(k));
    end
    step();
    at_neg();
    check("t4_full", disp_ready, 0);
    check("t4_none_ready", iss_valid, 0);
    step(); wb(3, 1);
    at_neg(); check("t4_wake_cycle", iss_valid, 0);
    for (int k = 0; k < N; k++) begin
      step();
      at_neg();
      check("t4_issue_valid", iss_valid, 1);
      check("t4_issue_dest", iss_dest, 8 + k);
      check("t4_disp_ready", disp_ready, k >= 1);
    end
    step();
    at_neg(); check("t4_empty", iss_valid, 0);

    // Flush with four busy entries (one ready and stalled) plus a same-cycle dispatch and wb.
    iss_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step(); disp(ALU_SLL, TAG_W'(16 + k), 1, TAG_W'(k), 0, 0, 0, 0);
    end
    step(); disp(ALU_SRL, 19, 0, 0, 9, 0, 0, 9);
    step();
    at_neg();
    check("t5_stalled_valid", iss_valid, 1);
    check("t5_stalled_dest", iss_dest, 19);
    step(); flush = 1; disp(ALU_ADD, 30, 0, 0, 1, 0, 0, 1); wb(0, 32'h77);
    at_neg(); check("t5_flush_iss_valid", iss_valid, 0);
    step(); iss_ready = 1;
    at_neg();
    check("t5_after_disp_ready", disp_ready, 1);
    check("t5_after_iss_valid", iss_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step(); wb(TAG_W'(k), 1);
      at_neg(); check("t5_stale_wb", iss_valid, 0);
    end
    step();
    at_neg(); check("t5_stale_issue", iss_valid, 0);

    // Slot 3 allocated before slot 0 is reused; both become ready together.
    step(); disp(ALU_ADD, 20, 1, 10, 0, 0, 0, 0);
    step(); disp(ALU_ADD, 21, 1, 11, 0, 0, 0, 0);
    step(); disp(ALU_ADD, 22, 1, 12, 0, 0, 0, 0);
    step(); disp(ALU_ADD, 23, 1, 14, 0, 0, 0, 3);
    step(); wb(10, 5);
    step();
    at_neg(); check("t6_slot0_dest", iss_dest, 20);
    step(); disp(ALU_ADD, 24, 1, 14, 0, 0, 0, 4);
    step(); wb(14, 7);
    step();
    at_neg();
    check("t6_first_valid", iss_valid, 1);
`ifdef RS_AGE_SELECT_EN
    check("t6_first_dest", iss_dest, 23);
`else
    check("t6_first_dest", iss_dest, 24);
`endif
    step();
    at_neg();
`ifdef RS_AGE_SELECT_EN
    check("t6_second_dest", iss_dest, 24);
`else
    check("t6_second_dest", iss_dest, 23);
`endif
    step(); wb(11, 8);
    step(); wb(12, 9);
    repeat (4) step();
    at_neg();
    check("t6_final_empty", iss_valid, 0);
    check("t6_final_ready", disp_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
